// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Holds the fetch PC and issues one instruction-memory read per cycle while
// queue credit remains. The single read in flight is tracked until its data
// returns, and that data is then written into a small circular fetch queue
// that feeds decode. A redirect or a reset flushes the queue and discards any
// response still outstanding.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetchPc,
  input  logic        fetchHit,
  input  logic [31:0] fetchTarget,
  output logic        imemReq,
  input  logic [31:0] imemRdata,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        decValid,
  input  logic        decReady,
  output logic [31:0] decInstr,
  output logic [31:0] decPc,
  output logic [31:0] decPredTarget,
  output logic        decPredTaken
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FQ_DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        predTaken;
    logic [31:0] predNextPc;
  } fqEntry_t;

  // Architectural fetch state.
  logic [31:0] pcReg;

  // The one outstanding imem read; its data arrives the following cycle.
  logic        ifValid;
  logic [31:0] ifPc;
  logic        ifPredTaken;
  logic [31:0] ifPredNextPc;

  // Fetch queue.
  fqEntry_t             fq [FQ_DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;

  // Per-cycle decisions.
  logic             issue;
  logic             push;
  logic             pop;
  logic [31:0]      nextPc;
  logic [CNT_W-1:0] credits;

  // Decide issue/push/pop and pick the next sequential or predicted PC.
  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    issue   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    nextPc  = pcReg + 32'd4;
    credits = count + CNT_W'(ifValid);
    // Credit uses the occupancy before any pop in this cycle, so the queue
    // plus the in-flight read can never exceed its depth.
    if (!rst && !redirect) begin
      issue = credits < DEPTH_CNT;
      push  = ifValid;
      pop   = (count != '0) && decReady;
    end
    if (fetchHit) nextPc = fetchTarget;
  end

  // PC, in-flight slot, and queue pointers; reset beats redirect beats the rest.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcReg   <= RESET_PC;
      ifValid <= 1'b0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (redirect) begin
      // Flushing clears the in-flight slot, so the response arriving next
      // cycle is never written.
      pcReg   <= redirectPc & 32'hFFFF_FFFC;
      ifValid <= 1'b0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (issue) begin
        pcReg        <= nextPc;
        ifValid      <= 1'b1;
        ifPc         <= pcReg;
        ifPredTaken  <= fetchHit;
        ifPredNextPc <= nextPc;
      end else begin
        ifValid <= 1'b0;
      end
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue payload write at the tail when the in-flight response lands.
  // NOTE: the storage array has no reset; occupancy is tracked by count, and
  // the data outputs are don't-care whenever decValid is low.
  always_ff @(posedge clk) begin
    if (push) begin
      fq[tail] <= '{instr:      imemRdata,
                    pc:         ifPc,
                    predTaken:  ifPredTaken,
                    predNextPc: ifPredNextPc};
    end
  end

  assign fetchPc       = pcReg;
  assign imemReq       = issue;
  assign decValid      = !rst && (count != '0);
  assign decInstr      = fq[head].instr;
  assign decPc         = fq[head].pc;
  assign decPredTaken  = fq[head].predTaken;
  assign decPredTarget = fq[head].predNextPc;

endmodule
